// File: rtl/accel_filter_pkg.sv
// accel_filter_pkg
// Shared definitions for the accelerometer FIR filter:
//   FIR_DEFAULT_COEFS : 8-tap Q1.15 moving average (8 x 4096 = 1.0)
//   fir_state_t       : controller states IDLE / MAC / OUT
//   clog2             : ceiling log2 used for index and accumulator sizing
package accel_filter_pkg;

  localparam int DEF_NTAPS  = 8;
  localparam int DEF_COEF_W = 16;

  // Tap k lives in bits [k*COEF_W +: COEF_W].
  localparam logic [DEF_NTAPS*DEF_COEF_W-1:0] FIR_DEFAULT_COEFS = {DEF_NTAPS{16'h1000}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// fir_sample_ring
// Circular history of the last NTAPS samples.
//   clk, reset_n : clock, asynchronous active-low reset (clears all entries)
//   wr_en        : store wr_data at the write pointer and advance it
//   wr_data      : sample to store
//   rd_idx       : age of the sample to read (0 = newest written)
//   rd_data      : combinational read of the selected entry
module fir_sample_ring
  import accel_filter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NTAPS  = 8,
  parameter int IDX_W  = clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic        [IDX_W-1:0]  rd_idx,
  output logic signed [DATA_W-1:0] rd_data
);

  localparam logic [IDX_W:0] NTAPS_EXT = (IDX_W+1)'(NTAPS);

  logic signed [DATA_W-1:0] mem [NTAPS];
  logic [IDX_W-1:0]         wr_ptr;
  logic [IDX_W-1:0]         newest;
  logic [IDX_W:0]           back_raw;
  logic [IDX_W:0]           back_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      // Explicit wrap so NTAPS does not have to be a power of two.
      wr_ptr <= (wr_ptr == IDX_W'(NTAPS-1)) ? '0 : wr_ptr + IDX_W'(1);
    end
  end

  // The newest sample sits one slot behind the write pointer.
  assign newest = (wr_ptr == '0) ? IDX_W'(NTAPS-1) : wr_ptr - IDX_W'(1);

  // (newest - rd_idx) mod NTAPS, computed one bit wider to stay non-negative.
  always_comb begin
    back_raw  = {1'b0, newest} + NTAPS_EXT - {1'b0, rd_idx};
    back_addr = back_raw;
    if (back_raw >= NTAPS_EXT) back_addr = back_raw - NTAPS_EXT;
  end

  assign rd_data = mem[back_addr[IDX_W-1:0]];

endmodule

// File: rtl/accel_fir_filter.sv
// accel_fir_filter
// Sequential-MAC FIR low-pass filter for signed accelerometer samples.
// One tap per cycle through a single multiplier; result is rounded
// (half up), shifted by FRAC_BITS and saturated to DATA_W.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data : sample handshake (ready only in IDLE)
//   out_data     : last filtered result, held between results
//   out_valid    : one-cycle pulse while a new out_data is first shown
//   overrun      : sticky, a sample was presented while busy
//   clr_overrun  : clears overrun (a simultaneous new drop wins)
module accel_fir_filter
  import accel_filter_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NTAPS     = 8,
  parameter int COEF_W    = 16,
  parameter int FRAC_BITS = 15,
  parameter logic [NTAPS*COEF_W-1:0] COEFS = FIR_DEFAULT_COEFS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam int IDX_W  = clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + IDX_W;

  localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(longint'(1) << (FRAC_BITS-1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  fir_state_t               state;
  logic [IDX_W-1:0]         k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  acc_round;
  logic signed [ACC_W-1:0]  acc_shift;
  logic signed [DATA_W-1:0] sat_result;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] sample;
  logic signed [COEF_W-1:0] coef_tab [NTAPS];
  logic                     wr_en;

  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_coef
      assign coef_tab[gi] = COEFS[gi*COEF_W +: COEF_W];
    end
  endgenerate

  assign in_ready = (state == IDLE);
  assign wr_en    = in_valid && (state == IDLE);

  fir_sample_ring #(
    .DATA_W (DATA_W),
    .NTAPS  (NTAPS),
    .IDX_W  (IDX_W)
  ) u_ring (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_idx  (k),
    .rd_data (sample)
  );

  assign prod     = sample * coef_tab[k];
  assign acc_next = acc + ACC_W'(prod);

  // Round/saturate is taken from acc_next so the result is already
  // registered when the OUT cycle begins.
  always_comb begin
    acc_round  = acc_next + ROUND_K;
    acc_shift  = acc_round >>> FRAC_BITS;
    sat_result = DATA_W'(acc_shift);
    if (acc_shift > SAT_MAX) sat_result = DATA_W'(SAT_MAX);
    else if (acc_shift < SAT_MIN) sat_result = DATA_W'(SAT_MIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && state != IDLE) overrun <= 1'b1;
      else if (clr_overrun)          overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (k == IDX_W'(NTAPS-1)) begin
            out_data  <= sat_result;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            k <= k + IDX_W'(1);
          end
        end
        OUT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_fir_filter.sv
// tb_accel_fir_filter
// Directed checks of the FIR filter: reset state, impulse, step, rounding,
// saturation (second instance with all-32767 coefficients), overrun
// handling and reset during MAC.
module tb_accel_fir_filter;
  import accel_filter_pkg::*;

  localparam logic [127:0] SAT_COEFS = {8{16'h7FFF}};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic clr_overrun = 1'b0;
  logic signed [15:0] in_data = '0;

  logic in_ready, out_valid, overrun;
  logic signed [15:0] out_data;
  logic sat_in_ready, sat_out_valid, sat_overrun;
  logic signed [15:0] sat_out_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  accel_fir_filter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  accel_fir_filter #(.COEFS(SAT_COEFS)) dut_sat (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (sat_in_ready),
    .in_data     (in_data),
    .out_data    (sat_out_data),
    .out_valid   (sat_out_valid),
    .overrun     (sat_overrun),
    .clr_overrun (clr_overrun)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    clr_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // One sample through the filter; optionally presents a 500 sample
  // (and clr_overrun) during MAC. lat is cycles from accept to out_valid.
  task automatic send(input int x, input bit inject, input bit inj_clr,
                      output int y, output int lat, output int sat_y);
    int n;
    wait_ready();
    in_data = 16'(x);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    lat = -1;
    while (n < 50) begin
      if (inject && n == 2) begin
        in_valid = 1'b1;
        in_data = 16'sd500;
        clr_overrun = inj_clr;
      end else begin
        in_valid = 1'b0;
        clr_overrun = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (out_valid) begin
        lat = n + 1;
        break;
      end
    end
    in_valid = 1'b0;
    clr_overrun = 1'b0;
    y = out_data;
    sat_y = sat_out_data;
    $display("txn in=%0d out=%0d sat_out=%0d latency=%0d", x, y, sat_y, lat);
  endtask

  task automatic run(input string tag, input int x, input int exp);
    int y, lat, sy;
    send(x, 1'b0, 1'b0, y, lat, sy);
    check_eq({tag, "_out"}, y, exp);
    check_eq({tag, "_lat"}, lat, 9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int y, lat, sy, pulses;

    // 1. reset state
    do_reset();
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_overrun", overrun, 0);

    // 2. impulse: 2048 for eight results, then 0
    run("imp0", 16384, 2048);
    @(posedge clk);
    #1;
    check_eq("imp_pulse_one_cycle", out_valid, 0);
    for (int i = 1; i < 8; i++) run($sformatf("imp%0d", i), 0, 2048);
    run("imp8", 0, 0);

    // 3. step: 125, 250, ... 1000, then held
    do_reset();
    for (int i = 1; i <= 10; i++) run($sformatf("step%0d", i), 1000, (i < 8 ? i : 8) * 125);

    // rounding from cleared history
    do_reset();
    run("round4", 4, 1);
    do_reset();
    run("round1", 1, 0);

    // 4. saturation on the all-32767 instance
    do_reset();
    for (int i = 0; i < 8; i++) send(32767, 1'b0, 1'b0, y, lat, sy);
    check_eq("sat_pos", sy, 32767);
    for (int i = 0; i < 8; i++) send(-32768, 1'b0, 1'b0, y, lat, sy);
    check_eq("sat_neg", sy, -32768);

    // 5. overrun
    do_reset();
    send(1000, 1'b1, 1'b0, y, lat, sy);
    check_eq("ovr_result", y, 125);
    check_eq("ovr_flag_set", overrun, 1);
    run("ovr_next", 1000, 250);
    send(1000, 1'b1, 1'b1, y, lat, sy);
    check_eq("ovr_clr_result", y, 375);
    check_eq("ovr_set_wins", overrun, 1);
    wait_ready();
    clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    check_eq("ovr_cleared", overrun, 0);

    // 6. reset during MAC
    wait_ready();
    in_data = 16'sd16384;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_eq("midrst_out_data", out_data, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1 pulses += int'(out_valid);
    end
    reset_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1 pulses += int'(out_valid);
    end
    check_eq("midrst_no_pulse", pulses, 0);
    run("midrst_zero", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
